// File: rtl/seq_scan_ctrl_if.sv
// seq_scan_ctrl_if -- request/response bundle of the scan controller.
//
// Parameters:
//   N      word width in bits
//   CNT_W  hit counter width
// Signals:
//   start      requester -> controller   request a scan (taken only when idle)
//   data_in    requester -> controller   word to serialize, sampled with start
//   busy       controller -> requester   scan in progress (shift + flush)
//   done       controller -> requester   one-cycle pulse when hit_count is final
//   hit_count  controller -> requester   hits of the last scan, held until next start
// Modports: master = requester side, slave = controller side.
interface seq_scan_ctrl_if #(
  parameter int N     = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [N-1:0]     data_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output start,
    output data_in,
    input  busy,
    input  done,
    input  hit_count
  );

  modport slave (
    input  start,
    input  data_in,
    output busy,
    output done,
    output hit_count
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl -- sequencing controller for the bit-serial 10110 detector.
//
// Takes an N-bit word on an accepted start, holds the external detector in
// reset while idle, feeds the word into it one bit per clock, then spends one
// flush cycle sampling the detector's answer to the last bit. Detector hits
// seen during shift and flush are counted (saturating) and reported with a
// one-cycle done pulse.
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   bus      slave modport of seq_scan_ctrl_if (start/data_in/busy/done/hit_count)
//   det_w    in   detector output w
//   det_j    out  detector input j (registered)
//   det_rst  out  detector reset, active high (registered)
//
// Build option:
//   SCAN_MSB_FIRST_EN  defined: data_in[N-1] is sent first;
//                      undefined (default): data_in[0] is sent first.
module seq_scan_ctrl #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_scan_ctrl_if.slave bus,
  input  logic          det_w,
  output logic          det_j,
  output logic          det_rst
);

  localparam int               IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  // Holds the bits still to be sent; the bit on det_j is already out of it.
  logic [N-1:0]     shift_reg, shift_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] hit_reg, hit_next;
  logic             det_j_reg, det_j_next;
  logic             det_rst_reg, det_rst_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             accept;
  logic             first_bit;   // bit sent in the first shift cycle
  logic [N-1:0]     load_word;   // remaining bits after first_bit
  logic             next_bit;    // bit sent next while shifting
  logic [N-1:0]     shifted;     // shift_reg after handing out next_bit

  assign accept = (state_reg == IDLE) && bus.start;

`ifdef SCAN_MSB_FIRST_EN
  assign first_bit = bus.data_in[N-1];
  assign load_word = {bus.data_in[N-2:0], 1'b0};
  assign next_bit  = shift_reg[N-1];
  assign shifted   = {shift_reg[N-2:0], 1'b0};
`else
  assign first_bit = bus.data_in[0];
  assign load_word = {1'b0, bus.data_in[N-1:1]};
  assign next_bit  = shift_reg[0];
  assign shifted   = {1'b0, shift_reg[N-1:1]};
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      idx_reg     <= '0;
      hit_reg     <= '0;
      det_j_reg   <= 1'b0;
      det_rst_reg <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      idx_reg     <= idx_next;
      hit_reg     <= hit_next;
      det_j_reg   <= det_j_next;
      det_rst_reg <= det_rst_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (idx_reg == LAST_IDX) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath logic. Outputs are decoded from the upcoming state so
  // that they leave the block straight from flops.
  always_comb begin
    det_j_next   = 1'b0;
    det_rst_next = 1'b1;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    shift_next   = shift_reg;
    idx_next     = idx_reg;
    hit_next     = hit_reg;

    case (state_next)
      SHIFT: begin
        det_rst_next = 1'b0;
        busy_next    = 1'b1;
        det_j_next   = accept ? first_bit : next_bit;
      end
      FLUSH: begin
        det_rst_next = 1'b0;
        busy_next    = 1'b1;
      end
      DONE:    done_next = 1'b1;
      default: ;
    endcase

    if (accept) begin
      shift_next = load_word;
      idx_next   = '0;
      hit_next   = '0;
    end else begin
      if (state_reg == SHIFT) begin
        shift_next = shifted;
        idx_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
      end
      // det_w lags det_j by one cycle, so the last bit's hit shows in FLUSH.
      if (((state_reg == SHIFT) || (state_reg == FLUSH)) && det_w &&
          (hit_reg != CNT_MAX)) begin
        hit_next = hit_reg + CNT_W'(1);
      end
    end
  end

  assign det_j         = det_j_reg;
  assign det_rst       = det_rst_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.hit_count = hit_reg;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl -- directed bench for seq_scan_ctrl, N=8.
// Two controllers share the clock: the main one (CNT_W=4) and a CNT_W=1 one
// for saturation. Each drives its own behavioural 10110 Moore detector.
`timescale 1ns/1ps
module tb_seq_scan_ctrl;

  localparam int N = 8;

  // Words chosen so the serialized bit stream is the same in both builds.
`ifdef SCAN_MSB_FIRST_EN
  localparam logic [7:0] W_ONE = 8'hB0;
  localparam logic [7:0] W_TWO = 8'hB6;
`else
  localparam logic [7:0] W_ONE = 8'h0D;
  localparam logic [7:0] W_TWO = 8'h6D;
`endif
  // Serialized stream, bit k = bit sent in the k-th shift cycle.
  localparam logic [7:0] J_ONE = 8'h0D;  // 1,0,1,1,0,0,0,0
  localparam logic [7:0] J_TWO = 8'h6D;  // 1,0,1,1,0,1,1,0
  localparam logic [7:0] J_FF  = 8'hFF;

  logic clk;
  logic rst;

  seq_scan_ctrl_if #(.N(N), .CNT_W(4)) bus ();
  seq_scan_ctrl_if #(.N(N), .CNT_W(1)) sbus ();

  logic det_w, det_j, det_rst;
  logic sdet_w, sdet_j, sdet_rst;

  seq_scan_ctrl #(.N(N), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .det_w   (det_w),
    .det_j   (det_j),
    .det_rst (det_rst)
  );

  seq_scan_ctrl #(.N(N), .CNT_W(1)) dut_sat (
    .clk     (clk),
    .rst     (rst),
    .bus     (sbus),
    .det_w   (sdet_w),
    .det_j   (sdet_j),
    .det_rst (sdet_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 10110 Moore detector with overlap; state 5 = pattern complete (w=1).
  function automatic logic [2:0] det_step(input logic [2:0] s, input logic j);
    case (s)
      3'd0:    det_step = j ? 3'd1 : 3'd0;
      3'd1:    det_step = j ? 3'd1 : 3'd2;
      3'd2:    det_step = j ? 3'd3 : 3'd0;
      3'd3:    det_step = j ? 3'd4 : 3'd2;
      3'd4:    det_step = j ? 3'd1 : 3'd5;
      3'd5:    det_step = j ? 3'd3 : 3'd0;
      default: det_step = 3'd0;
    endcase
  endfunction

  logic [2:0] ds, sds;
  always @(posedge clk) begin
    if (det_rst)  ds  <= 3'd0; else ds  <= det_step(ds, det_j);
    if (sdet_rst) sds <= 3'd0; else sds <= det_step(sds, sdet_j);
  end
  assign det_w  = (ds == 3'd5);
  assign sdet_w = (sds == 3'd5);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance one clock; sample/drive 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a scan of 'data' and follow it to the done pulse. Returns the
  // cycle offset of done from the accept edge (-1 if never), busy and
  // det_rst-low cycle counts, the det_j stream and hit_count seen in FLUSH.
  // With keep_start the start stays high and data_in changes mid-scan.
  task automatic run_scan(input logic [7:0] data, input bit keep_start,
                          output int lat, output int busy_n, output int drst_low,
                          output logic [7:0] jseq, output int hit_flush);
    int  cyc;
    bit  found;
    bus.data_in = data;
    bus.start   = 1'b1;
    tick();
    if (!keep_start) bus.start = 1'b0;
    cyc = 1; found = 0; lat = -1; busy_n = 0; drst_low = 0; jseq = '0; hit_flush = -1;
    while (cyc <= 30 && !found) begin
      if (cyc <= N) jseq[cyc-1] = det_j;
      if (keep_start && cyc == 4) bus.data_in = 8'hFF;
      if (cyc == N + 1) hit_flush = int'(bus.hit_count);
      if (bus.busy) busy_n++;
      if (!det_rst) drst_low++;
      if (bus.done) begin
        found = 1;
        lat   = cyc;
      end else begin
        tick();
        cyc++;
      end
    end
    $display("scan data=0x%02h lat=%0d busy=%0d j=0x%02h hits=%0d",
             data, lat, busy_n, jseq, bus.hit_count);
  endtask

  int         lat, busy_n, drst_low, hit_flush, dones, cyc;
  logic [7:0] jseq;

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b1;      // start during reset must be ignored
    bus.data_in  = 8'h0D;
    sbus.start   = 1'b0;
    sbus.data_in = 8'h00;

    // Reset then idle.
    tick(); tick();
    check("rst_det_rst", det_rst, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hit", bus.hit_count, 0);
    bus.start = 1'b0;
    rst       = 1'b0;
    tick(); tick();
    check("rst_no_scan", {bus.busy, ~det_rst}, 0);

    // Single hit.
    run_scan(W_ONE, 0, lat, busy_n, drst_low, jseq, hit_flush);
    check("one_lat", lat, N + 2);
    check("one_busy_cycles", busy_n, N + 1);
    check("one_det_rst_low", drst_low, N + 1);
    check("one_jseq", jseq, J_ONE);
    check("one_hit", bus.hit_count, 1);
    check("one_done_det_rst", det_rst, 1);
    tick();
    check("one_done_pulse", bus.done, 0);
    check("one_hit_held", bus.hit_count, 1);

    // Two overlapping hits, the second only counted in FLUSH.
    run_scan(W_TWO, 0, lat, busy_n, drst_low, jseq, hit_flush);
    check("two_lat", lat, N + 2);
    check("two_jseq", jseq, J_TWO);
    check("two_hit_in_flush", hit_flush, 1);
    check("two_hit", bus.hit_count, 2);
    tick();

    // Start held high through the whole scan; data_in changes mid-scan.
    run_scan(W_ONE, 1, lat, busy_n, drst_low, jseq, hit_flush);
    check("hold_lat", lat, N + 2);
    check("hold_jseq", jseq, J_ONE);
    check("hold_hit", bus.hit_count, 1);
    tick();   // IDLE after DONE; start is taken at the end of this cycle
    check("hold_idle_state", {bus.done, bus.busy}, 0);
    check("hold_idle_hit", bus.hit_count, 1);
    tick();
    check("hold_next_accept", bus.busy, 1);
    check("hold_next_hit_clr", bus.hit_count, 0);
    bus.start = 1'b0;
    cyc = 1; jseq = '0;
    while (cyc <= 30 && !bus.done) begin
      if (cyc <= N) jseq[cyc-1] = det_j;
      tick();
      cyc++;
    end
    $display("scan data=0xff lat=%0d j=0x%02h hits=%0d", cyc, jseq, bus.hit_count);
    check("ff_lat", cyc, N + 2);
    check("ff_jseq", jseq, J_FF);
    check("ff_hit", bus.hit_count, 0);
    tick();

    // Reset during the 4th shift cycle.
    bus.data_in = W_TWO;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    check("mid_in_shift", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_det_rst", det_rst, 1);
    check("mid_busy", bus.busy, 0);
    check("mid_hit", bus.hit_count, 0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) dones++;
      tick();
    end
    check("mid_no_done", dones, 0);
    check("mid_still_idle", bus.busy, 0);
    run_scan(8'h00, 0, lat, busy_n, drst_low, jseq, hit_flush);
    check("zero_lat", lat, N + 2);
    check("zero_hit", bus.hit_count, 0);
    tick();

    // Saturation with a 1-bit counter.
    sbus.data_in = W_TWO;
    sbus.start   = 1'b1;
    tick();
    sbus.start = 1'b0;
    cyc = 1;
    while (cyc <= 30 && !sbus.done) begin
      tick();
      cyc++;
    end
    $display("sat scan data=0x%02h lat=%0d hits=%0d", W_TWO, cyc, sbus.hit_count);
    check("sat_lat", cyc, N + 2);
    check("sat_hit", sbus.hit_count, 1);
    tick(); tick();
    check("sat_hit_held", sbus.hit_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
